// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The master modport belongs to the environment; the slave modport belongs to the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NumReq = 4
);
  logic [8*NumReq-1:0] ReqData;
  logic [NumReq-1:0]   ReqValid;
  logic [NumReq-1:0]   ReqLast;
  logic [NumReq-1:0]   ReqReady;
  logic [7:0]          TxData;
  logic                TxValid;
  logic                TxReady;
  logic [NumReq-1:0]   Grant;
  logic                Busy;

  modport master (
    output ReqData, ReqValid, ReqLast, TxReady,
    input  ReqReady, TxData, TxValid, Grant, Busy
  );

  modport slave (
    input  ReqData, ReqValid, ReqLast, TxReady,
    output ReqReady, TxData, TxValid, Grant, Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART transmitter byte port among NumReq requesters.
// A grant lasts until a Last byte, MaxBurst bytes, or TimeoutCycles idle cycles from the grantee.
module uart_tx_arbiter #(
  parameter int NumReq        = 4,
  parameter int MaxBurst      = 16,
  parameter int TimeoutCycles = 1024
) (
  input logic              Clock,
  input logic              Reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NumReq);
  localparam int BW = $clog2(MaxBurst + 1);
  localparam int IW = $clog2(TimeoutCycles + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]        state;
  logic [PW-1:0]     g_idx;
  logic [PW-1:0]     ptr;
  logic [BW-1:0]     byte_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [7:0]        tx_data;
  logic              tx_valid;

  logic [7:0]        req_bytes [NumReq];
  logic [PW-1:0]     pick;
  logic              pick_found;
  logic [PW-1:0]     cand_idx;
  logic              g_valid;
  logic              accept;
  logic              last_hit;
  logic              idle_hit;
  logic              release_grant;
  logic [NumReq-1:0] grant_vec;
  logic [NumReq-1:0] ready_vec;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_bytes[i] = bus.ReqData[i*8 +: 8];
    end
  end

  // Scan ptr+1, ptr+2, ... so the previous grantee is considered last.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand_idx = PW'((32'(ptr) + k) % NumReq);
      if (!pick_found && bus.ReqValid[cand_idx]) begin
        pick       = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid       = bus.ReqValid[g_idx];
    accept        = (state == LOCK) && g_valid && (!tx_valid || bus.TxReady);
    last_hit      = accept && (bus.ReqLast[g_idx] || (byte_cnt == BW'(MaxBurst - 1)));
    idle_hit      = (state == LOCK) && !g_valid && (idle_cnt == IW'(TimeoutCycles - 1));
    release_grant = last_hit || idle_hit;
  end

  always_comb begin
    grant_vec = '0;
    ready_vec = '0;
    if (state == LOCK) begin
      grant_vec[g_idx] = 1'b1;
    end
    if (accept) begin
      ready_vec[g_idx] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      g_idx    <= '0;
      ptr      <= PW'(NumReq - 1);
      byte_cnt <= '0;
      idle_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      // Load and drain can coincide: the new byte simply replaces the departing one.
      if (accept) begin
        tx_data  <= req_bytes[g_idx];
        tx_valid <= 1'b1;
      end else if (tx_valid && bus.TxReady) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= LOCK;
            g_idx    <= pick;
            byte_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        LOCK: begin
          if (release_grant) begin
            state    <= IDLE;
            ptr      <= g_idx;
            byte_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            if (accept) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
            if (g_valid) begin
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TxData   = tx_data;
  assign bus.TxValid  = tx_valid;
  assign bus.Grant    = grant_vec;
  assign bus.ReqReady = ready_vec;
  assign bus.Busy     = (state == LOCK) || tx_valid;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester message queues feed the DUT,
// a transaction-level round-robin model predicts the transmitted byte stream.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int TO = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  uart_tx_arbiter_if #(.NumReq(NR)) bus ();

  uart_tx_arbiter #(
    .NumReq(NR),
    .MaxBurst(MB),
    .TimeoutCycles(TO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  logic [8:0]  rq [NR][$];
  logic [8:0]  mq [NR][$];
  logic [7:0]  exp_q [$];
  int          m_ptr = NR - 1;
  int unsigned pct = 100;
  logic [NR-1:0] last_acc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endfunction

  // Reference: each grant goes to the first requester with pending bytes after the
  // previous grantee, and takes bytes until Last, MaxBurst, or its data runs out.
  function automatic void model_run();
    int g;
    int cnt;
    logic [8:0] e;
    for (int guard = 0; guard < 1000; guard++) begin
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        if (g < 0 && mq[(m_ptr + k) % NR].size() > 0) g = (m_ptr + k) % NR;
      end
      if (g < 0) return;
      cnt = 0;
      do begin
        e = mq[g].pop_front();
        exp_q.push_back(e[7:0]);
        cnt++;
      end while (!e[8] && cnt < MB && mq[g].size() > 0);
      m_ptr = g;
    end
  endfunction

  function automatic bit any_rq();
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void load(int r, logic [8:0] e);
    rq[r].push_back(e);
    mq[r].push_back(e);
  endfunction

  function automatic void drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        bus.ReqValid[i]       = 1'b1;
        bus.ReqData[i*8 +: 8] = rq[i][0][7:0];
        bus.ReqLast[i]        = rq[i][0][8];
      end else begin
        bus.ReqValid[i]       = 1'b0;
        bus.ReqData[i*8 +: 8] = 8'h00;
        bus.ReqLast[i]        = 1'b0;
      end
    end
  endfunction

  task automatic step();
    @(negedge Clock);
    last_acc = bus.ReqValid & bus.ReqReady;
    @(posedge Clock);
    #1;
    for (int i = 0; i < NR; i++) if (last_acc[i]) void'(rq[i].pop_front());
    drive();
    bus.TxReady = ($urandom_range(0, 99) < pct);
  endtask

  task automatic wait_done(string nm, int limit);
    int n = 0;
    while ((exp_q.size() != 0 || any_rq() || bus.TxValid) && n < limit) begin
      step();
      n++;
    end
    chk(nm, {31'd0, (exp_q.size() == 0 && !any_rq() && !bus.TxValid)}, 32'd1);
  endtask

  // Monitor: every transmitter handshake must match the next predicted byte.
  always @(negedge Clock) begin
    if (Reset) begin
      chk("grant_onehot0", {31'd0, $onehot0(bus.Grant)}, 32'd1);
      chk("ready_within_grant", 32'(bus.ReqReady & ~bus.Grant), 32'd0);
      chk("busy", {31'd0, bus.Busy}, {31'd0, (bus.Grant != '0) || bus.TxValid});
      if (bus.TxValid && bus.TxReady) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_tx: got %0h expected no byte at %0t", bus.TxData, $time);
        end else begin
          chk("tx_data", 32'(bus.TxData), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] held;
    int n;
    int len;
    bus.TxReady = 1'b0;
    drive();

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_grant", 32'(bus.Grant), 32'd0);
    chk("rst_txvalid", {31'd0, bus.TxValid}, 32'd0);
    chk("rst_txdata", 32'(bus.TxData), 32'd0);
    chk("rst_ready", 32'(bus.ReqReady), 32'd0);
    Reset = 1'b1;

    // Single three-byte message from requester 1: latency and release
    pct = 100;
    bus.TxReady = 1'b1;
    load(1, {1'b0, 8'h41});
    load(1, {1'b0, 8'h42});
    load(1, {1'b1, 8'h43});
    model_run();
    drive();
    step();
    chk("t1_grant", 32'(bus.Grant), 32'b0010);
    chk("t1_ready", 32'(bus.ReqReady), 32'b0010);
    chk("t1_txvalid_early", {31'd0, bus.TxValid}, 32'd0);
    step();
    chk("t1_txvalid", {31'd0, bus.TxValid}, 32'd1);
    chk("t1_txdata", 32'(bus.TxData), 32'h41);
    step();
    step();
    chk("t1_release", 32'(bus.Grant), 32'd0);
    wait_done("t1_done", 50);

    // All requesters with single-byte Last messages, twice over
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NR; i++) load(i, {1'b1, 8'(8'h10 * i + m)});
    model_run();
    drive();
    wait_done("t2_done", 100);

    // Long stream against MaxBurst with a waiting requester
    for (int b = 0; b < 10; b++) load(0, {b == 9, 8'(8'hA0 + b)});
    load(2, {1'b0, 8'hC0});
    load(2, {1'b1, 8'hC1});
    model_run();
    drive();
    wait_done("t3_done", 200);

    // Transmitter stall mid-message
    for (int b = 0; b < 6; b++) load(0, {b == 5, 8'(8'h60 + b)});
    model_run();
    drive();
    step();
    step();
    pct = 0;
    step();
    held = bus.TxData;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t4_hold_valid", {31'd0, bus.TxValid}, 32'd1);
      chk("t4_hold_data", 32'(bus.TxData), 32'(held));
      chk("t4_hold_ready", 32'(bus.ReqReady), 32'd0);
    end
    pct = 100;
    wait_done("t4_done", 100);

    // Idle timeout: requester 3 sends one byte then goes quiet
    load(3, {1'b0, 8'h55});
    model_run();
    drive();
    n = 0;
    while (bus.Grant != 4'b1000 && n < 50) begin step(); n++; end
    chk("t5_grant3", 32'(bus.Grant), 32'b1000);
    load(1, {1'b1, 8'h66});
    model_run();
    drive();
    n = 0;
    last_acc = '0;
    while (!last_acc[3] && n < 50) begin step(); n++; end
    chk("t5_accepted", {31'd0, last_acc[3]}, 32'd1);
    for (int c = 0; c < TO - 1; c++) begin
      step();
      chk("t5_still_granted", 32'(bus.Grant), 32'b1000);
    end
    step();
    chk("t5_timeout_release", 32'(bus.Grant), 32'd0);
    step();
    chk("t5_next_grant", 32'(bus.Grant), 32'b0010);
    wait_done("t5_done", 50);

    // Randomized message mixes with random transmitter backpressure
    for (int r = 0; r < 8; r++) begin
      pct = $urandom_range(40, 100);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1 || (i == NR - 1 && !any_rq())) begin
          for (int m = 0; m < int'($urandom_range(1, 2)); m++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) load(i, {b == len - 1, 8'($urandom)});
          end
        end
      end
      model_run();
      drive();
      wait_done("rand_done", 3000);
    end

    // Asynchronous reset mid-burst
    pct = 100;
    for (int b = 0; b < 8; b++) load(0, {1'b0, 8'(8'h30 + b)});
    model_run();
    drive();
    step();
    step();
    chk("t6_pre_txvalid", {31'd0, bus.TxValid}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("t6_txvalid", {31'd0, bus.TxValid}, 32'd0);
    chk("t6_grant", 32'(bus.Grant), 32'd0);
    chk("t6_ready", 32'(bus.ReqReady), 32'd0);
    chk("t6_txdata", 32'(bus.TxData), 32'd0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      mq[i].delete();
    end
    m_ptr = NR - 1;
    drive();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < NR; i++) load(i, {1'b1, 8'(8'hE0 + i)});
    model_run();
    drive();
    step();
    chk("t6_first_grant", 32'(bus.Grant), 32'b0001);
    wait_done("t6_done", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
